// File: rtl/eq_load_sequencer.sv
// rtl/eq_load_sequencer.sv - FIFO-to-SRAM block loader and equation-solver job sequencer
//
// Purpose: on a rising edge of hps_ready, drain one framed coefficient block
// (header + N payload words) from the HPS-to-FPGA FIFO into SRAM, then hand
// the SRAM port to the solver, pulse solver_start and wait for solver_done.
// This block owns the SRAM port mux, so exactly one master drives SRAM.
//
// Ports:
//   clk_clk, reset_reset_n           clock, asynchronous active-low reset
//   hps_ready                        job request flag (rising edge = start)
//   fifo_read/readdata/waitrequest   FIFO data port
//   fifo_csr_address/read/readdata   FIFO CSR port (fill_level at address 0)
//   sram_*                           muxed SRAM port (loader or solver)
//   solver_address/chipselect/write/writedata  solver SRAM request
//   solver_readdata                  SRAM read data pass-through
//   solver_start, solver_done        solver handshake
//   busy, done, error, word_count    job status
module eq_load_sequencer #(
  parameter int         ADDR_W    = 8,
  parameter int         DATA_W    = 32,
  parameter logic [7:0] HDR_MAGIC = 8'hA5
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              hps_ready,
  output logic              fifo_read,
  input  logic [DATA_W-1:0] fifo_readdata,
  input  logic              fifo_waitrequest,
  output logic [2:0]        fifo_csr_address,
  output logic              fifo_csr_read,
  input  logic [31:0]       fifo_csr_readdata,
  output logic [ADDR_W-1:0] sram_address,
  output logic              sram_clken,
  output logic              sram_chipselect,
  output logic              sram_write,
  output logic [DATA_W-1:0] sram_writedata,
  output logic [3:0]        sram_byteenable,
  input  logic [DATA_W-1:0] sram_readdata,
  input  logic [ADDR_W-1:0] solver_address,
  input  logic              solver_chipselect,
  input  logic              solver_write,
  input  logic [DATA_W-1:0] solver_writedata,
  output logic [DATA_W-1:0] solver_readdata,
  output logic              solver_start,
  input  logic              solver_done,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_POLL,
    S_POLL_WAIT,
    S_XFER,
    S_WFLUSH,
    S_START,
    S_SOLVE,
    S_DONE,
    S_ERROR
  } state_e;

  state_e              state_q, state_d;
  logic                ready_prev_q;
  logic [ADDR_W:0]     remaining_q, remaining_d;
  logic [ADDR_W:0]     burst_q, burst_d;
  logic                hdr_pending_q, hdr_pending_d;
  logic                wr_pend_q, wr_pend_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [ADDR_W:0]     word_count_q, word_count_d;
  logic                done_q, done_d;
  logic                error_q, error_d;

  logic                start_edge;
  logic                hdr_bad;
  logic [ADDR_W:0]     frame_len;
  logic [31:0]         remaining_ext;
  logic                in_solve;

  assign start_edge    = hps_ready & ~ready_prev_q;
  assign hdr_bad       = (fifo_readdata[DATA_W-1 -: 8] != HDR_MAGIC);
  // Header length field encodes N-1, so 0 means a single payload word.
  assign frame_len     = {1'b0, fifo_readdata[ADDR_W-1:0]} + 1'b1;
  assign remaining_ext = {{(32-ADDR_W-1){1'b0}}, remaining_q};
  assign in_solve      = (state_q == S_SOLVE);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q       <= S_IDLE;
      ready_prev_q  <= 1'b0;
      remaining_q   <= '0;
      burst_q       <= '0;
      hdr_pending_q <= 1'b0;
      wr_pend_q     <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      word_count_q  <= '0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      ready_prev_q  <= hps_ready;
      remaining_q   <= remaining_d;
      burst_q       <= burst_d;
      hdr_pending_q <= hdr_pending_d;
      wr_pend_q     <= wr_pend_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      word_count_q  <= word_count_d;
      done_q        <= done_d;
      error_q       <= error_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    remaining_d   = remaining_q;
    burst_d       = burst_q;
    hdr_pending_d = hdr_pending_q;
    wr_pend_d     = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    word_count_d  = word_count_q;
    done_d        = done_q;
    error_d       = error_q;
    fifo_read     = 1'b0;
    fifo_csr_read = 1'b0;
    solver_start  = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start_edge) begin
          state_d       = S_POLL;
          done_d        = 1'b0;
          error_d       = 1'b0;
          word_count_d  = '0;
          remaining_d   = {{ADDR_W{1'b0}}, 1'b1};
          hdr_pending_d = 1'b1;
        end
      end

      S_POLL: begin
        fifo_csr_read = 1'b1;
        state_d       = S_POLL_WAIT;
      end

      S_POLL_WAIT: begin
        if (fifo_csr_readdata == 32'd0) begin
          state_d = S_POLL;
        end else begin
          burst_d = (fifo_csr_readdata < remaining_ext) ? fifo_csr_readdata[ADDR_W:0]
                                                        : remaining_q;
          state_d = S_XFER;
        end
      end

      S_XFER: begin
        fifo_read = 1'b1;
        if (!fifo_waitrequest) begin
          burst_d     = burst_q - 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (hdr_pending_q) begin
            if (hdr_bad) begin
              state_d = S_ERROR;
              error_d = 1'b1;
            end else begin
              remaining_d   = frame_len;
              hdr_pending_d = 1'b0;
            end
          end else begin
            // Payload word k lands at SRAM address k; the write strobe
            // goes out on the following cycle from the registered copy.
            wr_pend_d    = 1'b1;
            wr_addr_d    = word_count_q[ADDR_W-1:0];
            wr_data_d    = fifo_readdata;
            word_count_d = word_count_q + 1'b1;
          end
          if (!(hdr_pending_q && hdr_bad) && burst_d == '0) begin
            state_d = (remaining_d != '0) ? S_POLL : S_WFLUSH;
          end
        end
      end

      S_WFLUSH: state_d = S_START;

      S_START: begin
        solver_start = 1'b1;
        state_d      = S_SOLVE;
      end

      S_SOLVE: begin
        if (solver_done) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // SRAM port mux: the solver owns the port only while SOLVE is active.
  assign sram_address     = in_solve ? solver_address    : wr_addr_q;
  assign sram_clken       = in_solve ? solver_chipselect : wr_pend_q;
  assign sram_chipselect  = in_solve ? solver_chipselect : wr_pend_q;
  assign sram_write       = in_solve ? solver_write      : wr_pend_q;
  assign sram_writedata   = in_solve ? solver_writedata  : wr_data_q;
  assign sram_byteenable  = 4'hF;
  assign solver_readdata  = sram_readdata;

  assign fifo_csr_address = 3'd0;
  assign busy       = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);
  assign done       = done_q;
  assign error      = error_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_eq_load_sequencer.sv
// tb/tb_eq_load_sequencer.sv - randomized self-checking bench for eq_load_sequencer
module tb_eq_load_sequencer;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic        hps_ready = 1'b0;
  logic        fifo_read;
  logic [31:0] fifo_readdata;
  logic        fifo_waitrequest;
  logic [2:0]  fifo_csr_address;
  logic        fifo_csr_read;
  logic [31:0] fifo_csr_readdata;
  logic [7:0]  sram_address;
  logic        sram_clken, sram_chipselect, sram_write;
  logic [31:0] sram_writedata;
  logic [3:0]  sram_byteenable;
  logic [31:0] sram_readdata;
  logic [7:0]  solver_address = 8'd0;
  logic        solver_chipselect = 1'b0;
  logic        solver_write = 1'b0;
  logic [31:0] solver_writedata = 32'd0;
  logic [31:0] solver_readdata;
  logic        solver_start;
  logic        solver_done = 1'b0;
  logic        busy, done, error;
  logic [8:0]  word_count;

  always #5 clk_clk = ~clk_clk;

  eq_load_sequencer dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .hps_ready(hps_ready),
    .fifo_read(fifo_read), .fifo_readdata(fifo_readdata), .fifo_waitrequest(fifo_waitrequest),
    .fifo_csr_address(fifo_csr_address), .fifo_csr_read(fifo_csr_read),
    .fifo_csr_readdata(fifo_csr_readdata),
    .sram_address(sram_address), .sram_clken(sram_clken), .sram_chipselect(sram_chipselect),
    .sram_write(sram_write), .sram_writedata(sram_writedata), .sram_byteenable(sram_byteenable),
    .sram_readdata(sram_readdata),
    .solver_address(solver_address), .solver_chipselect(solver_chipselect),
    .solver_write(solver_write), .solver_writedata(solver_writedata),
    .solver_readdata(solver_readdata), .solver_start(solver_start), .solver_done(solver_done),
    .busy(busy), .done(done), .error(error), .word_count(word_count)
  );

  int vectors = 0;
  int miscompares = 0;

  // FIFO model: fifo_q holds the whole frame, avail is how many words the
  // HPS side has made visible. arrive_q scripts how many words appear at
  // each fill_level read; once empty, everything left becomes visible.
  logic [31:0] fifo_q[$];
  int          arrive_q[$];
  int          avail, pops, csr_reads, underflow;
  bit          stall_en = 1'b0;

  // SRAM / solver observation
  logic [31:0] mem [256];
  int          wlog_a[$];
  logic [31:0] wlog_d[$];
  int          start_cnt, cyc, last_pop_cyc, last_wr_cyc, start_cyc;

  // Expected payload, in the order it must appear at SRAM addresses 0..N-1.
  logic [31:0] exp_q[$];

  always @(posedge clk_clk) begin
    cyc++;
    if (fifo_read === 1'b1 && fifo_waitrequest === 1'b0) begin
      if (avail > 0 && fifo_q.size() > 0) begin
        void'(fifo_q.pop_front());
        avail--;
        pops++;
        last_pop_cyc = cyc;
      end else begin
        underflow++;
      end
    end
    if (fifo_csr_read === 1'b1) begin
      csr_reads++;
      if (arrive_q.size() > 0) avail = avail + arrive_q.pop_front();
      else avail = fifo_q.size();
      if (avail > fifo_q.size()) avail = fifo_q.size();
      fifo_csr_readdata <= 32'(avail);
    end
    fifo_readdata <= (fifo_q.size() > 0) ? fifo_q[0] : 32'd0;
    if (sram_chipselect === 1'b1 && sram_clken === 1'b1 && sram_write === 1'b1) begin
      mem[sram_address] <= sram_writedata;
      wlog_a.push_back(int'(sram_address));
      wlog_d.push_back(sram_writedata);
      last_wr_cyc = cyc;
    end
    sram_readdata <= mem[sram_address];
    if (solver_start === 1'b1) begin
      start_cnt++;
      start_cyc = cyc;
    end
  end

  always @(negedge clk_clk) fifo_waitrequest = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;

  // Number of SRAM writes that deviate from "payload k at address k".
  function automatic int log_errors();
    int e = 0;
    if (wlog_a.size() != exp_q.size()) e++;
    for (int i = 0; i < wlog_a.size() && i < exp_q.size(); i++)
      if (wlog_a[i] != i || wlog_d[i] !== exp_q[i]) e++;
    return e;
  endfunction

  function automatic logic [31:0] good_hdr(input int n);
    return {8'hA5, 16'h0000, 8'(n - 1)};
  endfunction

  task automatic load_frame(input logic [31:0] hdr, input int n);
    fifo_q.delete(); exp_q.delete(); arrive_q.delete();
    wlog_a.delete(); wlog_d.delete();
    fifo_q.push_back(hdr);
    for (int i = 0; i < n; i++) begin
      logic [31:0] w;
      w = $urandom;
      fifo_q.push_back(w);
      exp_q.push_back(w);
    end
    avail = 0; pops = 0; csr_reads = 0; underflow = 0; start_cnt = 0;
  endtask

  task automatic pulse_ready();
    hps_ready = 1'b1;
    @(negedge clk_clk);
    hps_ready = 1'b0;
  endtask

  task automatic wait_loaded(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk_clk);
      if (start_cnt > 0 || error === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic pulse_done();
    solver_done = 1'b1;
    @(negedge clk_clk);
    solver_done = 1'b0;
  endtask

  task automatic test_reset();
    fifo_q.delete(); arrive_q.delete(); avail = 0;
    hps_ready = 1'b1;
    reset_reset_n = 1'b0;
    repeat (2) @(negedge clk_clk);
    vectors++;
    if ({fifo_read, fifo_csr_read, sram_clken, sram_chipselect, sram_write, solver_start, busy, done, error} !== 9'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 000000000",
               {fifo_read, fifo_csr_read, sram_clken, sram_chipselect, sram_write, solver_start, busy, done, error});
    end
    vectors++;
    if (fifo_csr_address !== 3'd0 || sram_byteenable !== 4'hF) begin
      miscompares++;
      $display("FAIL reset_const: csr_address %h byteenable %h want 0 / f", fifo_csr_address, sram_byteenable);
    end
    vectors++;
    if (word_count !== 9'd0 || sram_address !== 8'd0 || sram_writedata !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_data: word_count %0d addr %h wdata %h want 0", word_count, sram_address, sram_writedata);
    end
    // hps_ready already high when reset releases must count as an edge.
    reset_reset_n = 1'b1;
    @(negedge clk_clk);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_edge: busy %b want 1", busy);
    end
    repeat (3) @(negedge clk_clk);
    hps_ready = 1'b0;
    reset_reset_n = 1'b0;
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    @(negedge clk_clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_reidle: busy %b want 0", busy);
    end
  endtask

  task automatic test_nominal();
    logic [31:0] pl [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    bit ok;
    load_frame(32'hA500_0003, 0);
    for (int i = 0; i < 4; i++) begin
      fifo_q.push_back(pl[i]);
      exp_q.push_back(pl[i]);
    end
    hps_ready = 1'b1;
    @(negedge clk_clk);
    vectors++;
    if (fifo_csr_read !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL nom_poll_cycle1: csr_read %b busy %b want 1 1", fifo_csr_read, busy);
    end
    @(negedge clk_clk);
    hps_ready = 1'b0;
    vectors++;
    if (fifo_read !== 1'b0 || fifo_csr_read !== 1'b0) begin
      miscompares++;
      $display("FAIL nom_cycle2: fifo_read %b csr_read %b want 0 0", fifo_read, fifo_csr_read);
    end
    @(negedge clk_clk);
    vectors++;
    if (fifo_read !== 1'b1) begin
      miscompares++;
      $display("FAIL nom_read_cycle3: fifo_read %b want 1", fifo_read);
    end
    wait_loaded(200, ok);
    vectors++;
    if (!ok || error !== 1'b0) begin
      miscompares++;
      $display("FAIL nom_load: reached %b error %b want 1 0", ok, error);
    end
    vectors++;
    if (log_errors() != 0) begin
      miscompares++;
      $display("FAIL nom_sram_image: %0d bad writes of %0d want 0", log_errors(), wlog_a.size());
    end
    vectors++;
    if (word_count !== 9'd4 || pops != 5 || underflow != 0) begin
      miscompares++;
      $display("FAIL nom_counts: word_count %0d pops %0d underflow %0d want 4 5 0", word_count, pops, underflow);
    end
    vectors++;
    if (last_wr_cyc != last_pop_cyc + 1 || start_cyc != last_pop_cyc + 2) begin
      miscompares++;
      $display("FAIL nom_pipeline: beat %0d write %0d start %0d want write=beat+1 start=beat+2",
               last_pop_cyc, last_wr_cyc, start_cyc);
    end
    solver_address = 8'd2; solver_chipselect = 1'b1; solver_write = 1'b0;
    @(negedge clk_clk);
    vectors++;
    if (sram_clken !== 1'b1 || sram_address !== 8'd2 || sram_write !== 1'b0 || sram_byteenable !== 4'hF) begin
      miscompares++;
      $display("FAIL nom_mux_solver: clken %b addr %h write %b be %h want 1 02 0 f",
               sram_clken, sram_address, sram_write, sram_byteenable);
    end
    vectors++;
    if (solver_readdata !== 32'h33) begin
      miscompares++;
      $display("FAIL nom_solver_read: got %h want 00000033", solver_readdata);
    end
    solver_address = 8'd9; solver_write = 1'b1; solver_writedata = 32'hCAFE_F00D;
    @(negedge clk_clk);
    solver_chipselect = 1'b0; solver_write = 1'b0;
    vectors++;
    if (mem[9] !== 32'hCAFE_F00D) begin
      miscompares++;
      $display("FAIL nom_solver_write: sram[9] %h want cafef00d", mem[9]);
    end
    pulse_done();
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0 || error !== 1'b0 || start_cnt != 1) begin
      miscompares++;
      $display("FAIL nom_done: done %b busy %b error %b starts %0d want 1 0 0 1", done, busy, error, start_cnt);
    end
    solver_chipselect = 1'b1; solver_write = 1'b1;
    #1;
    vectors++;
    if (sram_write !== 1'b0 || sram_chipselect !== 1'b0) begin
      miscompares++;
      $display("FAIL nom_mux_release: write %b cs %b want 0 0", sram_write, sram_chipselect);
    end
    solver_chipselect = 1'b0; solver_write = 1'b0;
  endtask

  task automatic test_fragmented();
    bit ok;
    load_frame(good_hdr(3), 3);
    arrive_q = '{1, 0, 0, 2, 1};
    pulse_ready();
    wait_loaded(300, ok);
    vectors++;
    if (!ok || csr_reads != 5) begin
      miscompares++;
      $display("FAIL frag_polls: reached %b csr_reads %0d want 1 5", ok, csr_reads);
    end
    vectors++;
    if (underflow != 0 || pops != 4 || log_errors() != 0 || word_count !== 9'd3) begin
      miscompares++;
      $display("FAIL frag_load: underflow %0d pops %0d bad %0d word_count %0d want 0 4 0 3",
               underflow, pops, log_errors(), word_count);
    end
    pulse_done();
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL frag_done: done %b want 1", done);
    end
  endtask

  task automatic test_stall();
    bit ok;
    for (int it = 0; it < 3; it++) begin
      int n;
      n = $urandom_range(5, 40);
      load_frame(good_hdr(n), n);
      for (int k = 0; k < 6; k++) arrive_q.push_back($urandom_range(0, 4));
      stall_en = 1'b1;
      pulse_ready();
      wait_loaded(3000, ok);
      stall_en = 1'b0;
      vectors++;
      if (!ok || log_errors() != 0 || word_count !== 9'(n)) begin
        miscompares++;
        $display("FAIL stall_load[%0d]: reached %b bad %0d word_count %0d want 1 0 %0d",
                 it, ok, log_errors(), word_count, n);
      end
      vectors++;
      if (pops != n + 1 || underflow != 0 || start_cnt != 1) begin
        miscompares++;
        $display("FAIL stall_fifo[%0d]: pops %0d underflow %0d starts %0d want %0d 0 1",
                 it, pops, underflow, start_cnt, n + 1);
      end
      pulse_done();
    end
  endtask

  task automatic test_bad_header();
    bit ok;
    int n;
    load_frame(32'h5A00_0001, 2);
    exp_q.delete();
    pulse_ready();
    wait_loaded(200, ok);
    repeat (3) @(negedge clk_clk);
    vectors++;
    if (!ok || error !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL bad_hdr_flag: reached %b error %b busy %b done %b want 1 1 0 0", ok, error, busy, done);
    end
    vectors++;
    if (pops != 1 || wlog_a.size() != 0 || start_cnt != 0 || word_count !== 9'd0) begin
      miscompares++;
      $display("FAIL bad_hdr_side: pops %0d writes %0d starts %0d word_count %0d want 1 0 0 0",
               pops, wlog_a.size(), start_cnt, word_count);
    end
    n = $urandom_range(2, 10);
    load_frame(good_hdr(n), n);
    pulse_ready();
    vectors++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL bad_hdr_clear: error %b busy %b want 0 1", error, busy);
    end
    wait_loaded(300, ok);
    pulse_done();
    vectors++;
    if (!ok || log_errors() != 0 || done !== 1'b1 || error !== 1'b0) begin
      miscompares++;
      $display("FAIL bad_hdr_recover: reached %b bad %0d done %b error %b want 1 0 1 0",
               ok, log_errors(), done, error);
    end
  endtask

  task automatic test_max_frame();
    bit ok;
    load_frame(32'hA500_00FF, 256);
    pulse_ready();
    wait_loaded(1000, ok);
    vectors++;
    if (!ok || word_count !== 9'd256 || log_errors() != 0) begin
      miscompares++;
      $display("FAIL max_frame: reached %b word_count %0d bad %0d want 1 256 0", ok, word_count, log_errors());
    end
    vectors++;
    if (wlog_a.size() != 256 || wlog_a[wlog_a.size() - 1] != 255) begin
      miscompares++;
      $display("FAIL max_last_addr: writes %0d last %0d want 256 255",
               wlog_a.size(), (wlog_a.size() > 0) ? wlog_a[wlog_a.size() - 1] : -1);
    end
    pulse_done();
  endtask

  task automatic test_reset_mid_xfer();
    bit ok;
    int n;
    load_frame(good_hdr(20), 20);
    pulse_ready();
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (pops == 5) ok = 1'b1;
      else @(negedge clk_clk);
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL midrst_reach: pops %0d want 5", pops);
    end
    reset_reset_n = 1'b0;
    #1;
    vectors++;
    if (sram_write !== 1'b0 || sram_chipselect !== 1'b0 || busy !== 1'b0 || word_count !== 9'd0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_state: write %b cs %b busy %b word_count %0d done %b want 0 0 0 0 0",
               sram_write, sram_chipselect, busy, word_count, done);
    end
    repeat (2) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    @(negedge clk_clk);
    n = $urandom_range(3, 12);
    load_frame(good_hdr(n), n);
    pulse_ready();
    wait_loaded(300, ok);
    vectors++;
    if (!ok || done !== 1'b0 || error !== 1'b0 || log_errors() != 0 || word_count !== 9'(n)) begin
      miscompares++;
      $display("FAIL midrst_reload: reached %b done %b error %b bad %0d word_count %0d want 1 0 0 0 %0d",
               ok, done, error, log_errors(), word_count, n);
    end
    pulse_done();
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_done: done %b want 1", done);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_fragmented();
    test_stall();
    test_bad_header();
    test_max_frame();
    test_reset_mid_xfer();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
